// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer: shadow config applied between frames, rx byte/flag FIFO
// drained over valid/ready. Optional error counters under `define UART_RX_ERR_CNT_EN.
module uart_rx_ctrl #(
  parameter int         DEPTH     = 4,
  parameter logic [5:0] PRESC_RST = 6'd8,
  parameter int         TO_BITS   = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cfg_wr,
  input  logic       cfg_par_en,
  input  logic       cfg_par_type,
  input  logic [5:0] cfg_presc,
  output logic       cfg_pend,
  input  logic       RX_IN,
  output logic       PAR_EN,
  output logic       PAR_TYPE,
  output logic [5:0] Prescale,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_par_err,
  input  logic       rx_stp_err,
  output logic [7:0] out_data,
  output logic       out_perr,
  output logic       out_serr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovf,
  input  logic       ovf_clr
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0] perr_cnt,
  output logic [7:0] serr_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, FRAME, APPLY} state_t;

  state_t     state;
  logic       sh_par_en;
  logic       sh_par_type;
  logic [5:0] sh_presc;
  logic [8:0] to_cnt;
  logic [8:0] to_lim;
  logic       any_flag;
  logic       any_prev;
  logic       ev;

  assign any_flag = rx_valid | rx_par_err | rx_stp_err;
  assign ev       = any_flag & ~any_prev;
  assign to_lim   = 9'(TO_BITS) * 9'(Prescale) - 9'd1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      to_cnt      <= '0;
      any_prev    <= 1'b0;
      cfg_pend    <= 1'b0;
      sh_par_en   <= 1'b0;
      sh_par_type <= 1'b0;
      sh_presc    <= PRESC_RST;
      PAR_EN      <= 1'b0;
      PAR_TYPE    <= 1'b0;
      Prescale    <= PRESC_RST;
    end else begin
      any_prev <= any_flag;
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state  <= FRAME;
            to_cnt <= '0;
          end else if (cfg_pend) begin
            state <= APPLY;
          end
        end
        FRAME: begin
          if (ev || to_cnt == to_lim) begin
            state  <= IDLE;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 9'd1;
          end
        end
        APPLY: begin
          PAR_EN   <= sh_par_en;
          PAR_TYPE <= sh_par_type;
          Prescale <= sh_presc;
          cfg_pend <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A write landing in APPLY must stay pending so it is applied next gap.
      if (cfg_wr) begin
        sh_par_en   <= cfg_par_en;
        sh_par_type <= cfg_par_type;
        sh_presc    <= cfg_presc;
        cfg_pend    <= 1'b1;
      end
    end
  end

  logic [9:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [9:0]  head;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = !empty && out_ready;
  assign push      = ev && (!full || pop);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : head[7:0];
  assign out_perr  = empty ? 1'b0  : head[8];
  assign out_serr  = empty ? 1'b0  : head[9];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {rx_stp_err, rx_par_err, rx_data};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (ev && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)       ovf <= 1'b0;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perr_cnt <= '0;
      serr_cnt <= '0;
    end else if (ovf_clr) begin
      perr_cnt <= '0;
      serr_cnt <= '0;
    end else if (ev) begin
      if (rx_par_err && perr_cnt != 8'hff) perr_cnt <= perr_cnt + 8'd1;
      if (rx_stp_err && serr_cnt != 8'hff) serr_cnt <= serr_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: config apply timing, frame timeout, FIFO order,
// overflow, simultaneous push/pop and async reset.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cfg_wr = 1'b0, cfg_par_en = 1'b0, cfg_par_type = 1'b0;
  logic [5:0] cfg_presc = 6'd0;
  logic       cfg_pend;
  logic       RX_IN = 1'b1;
  logic       PAR_EN, PAR_TYPE;
  logic [5:0] Prescale;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, rx_par_err = 1'b0, rx_stp_err = 1'b0;
  logic [7:0] out_data;
  logic       out_perr, out_serr, out_valid;
  logic       out_ready = 1'b0;
  logic       ovf;
  logic       ovf_clr = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] perr_cnt, serr_cnt;
  int         mdl_perr = 0, mdl_serr = 0;
`endif

  int         total = 0;
  int         bad = 0;
  logic [9:0] q[$];

  uart_rx_ctrl #(.DEPTH(DEPTH), .PRESC_RST(6'd8), .TO_BITS(12)) dut (
    .CLK(CLK), .RST(RST),
    .cfg_wr(cfg_wr), .cfg_par_en(cfg_par_en), .cfg_par_type(cfg_par_type),
    .cfg_presc(cfg_presc), .cfg_pend(cfg_pend),
    .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYPE(PAR_TYPE), .Prescale(Prescale),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
    .out_data(out_data), .out_perr(out_perr), .out_serr(out_serr),
    .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef UART_RX_ERR_CNT_EN
    , .perr_cnt(perr_cnt), .serr_cnt(serr_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One receiver event followed by an idle gap so the next one is a fresh edge.
  task automatic send_ev(input logic [7:0] d, input logic v, input logic pe, input logic se,
                         input logic clr);
    rx_data = d; rx_valid = v; rx_par_err = pe; rx_stp_err = se; ovf_clr = clr;
    if (q.size() < DEPTH) q.push_back({se, pe, d});
`ifdef UART_RX_ERR_CNT_EN
    if (clr) begin mdl_perr = 0; mdl_serr = 0; end
    else begin mdl_perr += int'(pe); mdl_serr += int'(se); end
`endif
    @(negedge CLK);
    rx_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0; ovf_clr = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pop_chk(input string tag);
    logic [9:0] e;
    e = (q.size() > 0) ? q.pop_front() : 10'h3ff;
    check_val({tag, "_vld"}, 32'(out_valid), 32'd1);
    check_val(tag, {22'd0, out_serr, out_perr, out_data}, {22'd0, e});
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    q.delete();
`ifdef UART_RX_ERR_CNT_EN
    mdl_perr = 0; mdl_serr = 0;
`endif
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge CLK);
    check_val("rst_par_en", 32'(PAR_EN), 32'd0);
    check_val("rst_par_type", 32'(PAR_TYPE), 32'd0);
    check_val("rst_presc", 32'(Prescale), 32'd8);
    check_val("rst_pend", 32'(cfg_pend), 32'd0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_data", {23'd0, out_serr, out_perr, out_data}, 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    RST = 1'b1;

    // frame timeout: start bit then line high, no event; apply follows timeout
    @(negedge CLK); RX_IN = 1'b0;
    @(negedge CLK); RX_IN = 1'b1;
    cfg_wr = 1'b1; cfg_presc = 6'd16; cfg_par_en = 1'b1; cfg_par_type = 1'b1;
    @(negedge CLK); cfg_wr = 1'b0;
    check_val("to_pend", 32'(cfg_pend), 32'd1);
    check_val("to_presc_early", 32'(Prescale), 32'd8);
    repeat (95) @(negedge CLK);
    check_val("to_presc_96", 32'(Prescale), 32'd8);
    @(negedge CLK);
    check_val("to_presc_97", 32'(Prescale), 32'd8);
    @(negedge CLK);
    check_val("to_presc_98", 32'(Prescale), 32'd16);
    check_val("to_par", {30'd0, PAR_EN, PAR_TYPE}, 32'd3);
    check_val("to_pend_clr", 32'(cfg_pend), 32'd0);

    // idle config apply: +2 clocks
    do_reset();
    check_val("rst2_presc", 32'(Prescale), 32'd8);
    cfg_wr = 1'b1; cfg_presc = 6'd16; cfg_par_en = 1'b1; cfg_par_type = 1'b0;
    @(negedge CLK); cfg_wr = 1'b0;
    check_val("idle_pend", 32'(cfg_pend), 32'd1);
    check_val("idle_presc_1", 32'(Prescale), 32'd8);
    @(negedge CLK);
    check_val("idle_presc_2", 32'(Prescale), 32'd8);
    @(negedge CLK);
    check_val("idle_presc_3", 32'(Prescale), 32'd16);
    check_val("idle_par", {30'd0, PAR_EN, PAR_TYPE}, 32'd2);
    check_val("idle_pend_clr", 32'(cfg_pend), 32'd0);

    // config held off during a frame, applied after rx_valid
    RX_IN = 1'b0;
    @(negedge CLK);
    cfg_wr = 1'b1; cfg_presc = 6'd32; cfg_par_en = 1'b0; cfg_par_type = 1'b1;
    @(negedge CLK); cfg_wr = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    check_val("frm_presc_hold", 32'(Prescale), 32'd16);
    check_val("frm_pend", 32'(cfg_pend), 32'd1);
    send_ev(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("frm_presc_p1", 32'(Prescale), 32'd16);
    @(negedge CLK);
    check_val("frm_presc_p2", 32'(Prescale), 32'd32);
    check_val("frm_par", {30'd0, PAR_EN, PAR_TYPE}, 32'd1);
    pop_chk("frm_byte");

    // basic capture with flags
    send_ev(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    send_ev(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    send_ev(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    pop_chk("cap_a5");
    pop_chk("cap_3c");
    pop_chk("cap_5a");
    check_val("cap_empty", 32'(out_valid), 32'd0);

    // overflow: 5 events into 4 entries
    for (int i = 1; i <= 5; i++) send_ev(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("ovf_set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; @(negedge CLK); ovf_clr = 1'b0;
    check_val("ovf_clr", 32'(ovf), 32'd0);
    send_ev(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("ovf_set_wins", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; @(negedge CLK); ovf_clr = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
    mdl_perr = 0; mdl_serr = 0;
`endif

    // full, push and pop in the same cycle
    check_val("both_head", {22'd0, out_serr, out_perr, out_data}, {22'd0, q.pop_front()});
    rx_data = 8'h06; rx_valid = 1'b1; out_ready = 1'b1;
    q.push_back(10'h006);
    @(negedge CLK); rx_valid = 1'b0; out_ready = 1'b0;
    @(negedge CLK);
    check_val("both_no_ovf", 32'(ovf), 32'd0);
    pop_chk("both_2");
    pop_chk("both_3");
    pop_chk("both_4");
    pop_chk("both_6");
    check_val("both_empty", 32'(out_valid), 32'd0);

    // push while empty with ready high: stored, no bypass
    out_ready = 1'b1;
    rx_data = 8'h77; rx_valid = 1'b1;
    @(negedge CLK); rx_valid = 1'b0;
    check_val("emp_vld", 32'(out_valid), 32'd1);
    check_val("emp_data", 32'(out_data), 32'h77);
    @(negedge CLK); out_ready = 1'b0;
    check_val("emp_drained", 32'(out_valid), 32'd0);

    // serr-flagged events feed the optional counters
    send_ev(8'h81, 1'b1, 1'b1, 1'b1, 1'b0);
    send_ev(8'h82, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef UART_RX_ERR_CNT_EN
    check_val("cnt_perr", 32'(perr_cnt), 32'(mdl_perr));
    check_val("cnt_serr", 32'(serr_cnt), 32'(mdl_serr));
`endif

    // async reset mid-frame discards FIFO and config
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check_val("arst_valid", 32'(out_valid), 32'd0);
    check_val("arst_presc", 32'(Prescale), 32'd8);
    check_val("arst_par", {30'd0, PAR_EN, PAR_TYPE}, 32'd0);
    q.delete();
    RX_IN = 1'b1;
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_val("arst_idle_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
